// File: rtl/bp_pkg.sv
// Shared types and helpers for the BTB/PHT branch predictor.
package bp_pkg;

  typedef enum logic [1:0] {
    BP_STATIC  = 2'd0,
    BP_BIMODAL = 2'd1,
    BP_GSHARE  = 2'd2
  } bp_mode_e;

  // Tag field is sized for the smallest legal index (IDX_W=2); narrower tags are zero-extended.
  localparam int unsigned BP_TAG_MAX_W = 28;
  localparam int unsigned BP_CNT_MAX_W = 16;

  typedef struct packed {
    logic                    valid;
    logic                    uncond;
    logic [BP_TAG_MAX_W-1:0] tag;
    logic [31:0]             tgt;
  } btb_entry_t;

  typedef logic [BP_CNT_MAX_W-1:0] sat_cnt_t;

  function automatic sat_cnt_t sat_cnt_next(input sat_cnt_t cnt, input int unsigned cnt_w,
                                            input logic taken);
    sat_cnt_t max_v;
    max_v = sat_cnt_t'((32'd1 << cnt_w) - 32'd1);
    if (taken) return (cnt == max_v) ? cnt : cnt + sat_cnt_t'(1);
    return (cnt == '0) ? cnt : cnt - sat_cnt_t'(1);
  endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// Pattern history table: ENTRIES saturating counters, one combinational read port, one update port.
module bp_sat_counter_table
  import bp_pkg::*;
#(
  parameter  int unsigned ENTRIES = 64,
  parameter  int unsigned CNT_W   = 2,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_taken,
  input  logic             i_upd_vld,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken
);

  localparam logic [CNT_W-1:0] WEAK_TAKEN = CNT_W'(1) << (CNT_W - 1);

  logic [CNT_W-1:0] r_cnt [ENTRIES];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) r_cnt[i] <= WEAK_TAKEN;
    end else if (i_upd_vld) begin
      r_cnt[i_upd_idx] <= CNT_W'(sat_cnt_next(sat_cnt_t'(r_cnt[i_upd_idx]), CNT_W, i_upd_taken));
    end
  end

  assign o_rd_taken = r_cnt[i_rd_idx][CNT_W-1];

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with static, bimodal or gshare direction prediction and
// saturating branch/mispredict performance counters.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter  int unsigned ENTRIES = 64,
  parameter  int unsigned CNT_W   = 2,
  parameter  int unsigned GHR_W   = 6,
  parameter  int          MODE    = 1,
  parameter  int unsigned PERF_W  = 32,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_if_pc,
  output logic              o_pred_hit,
  output logic              o_pred_taken,
  output logic [31:0]       o_pred_target,
  output logic [IDX_W-1:0]  o_pred_idx,
  input  logic              i_ex_upd_vld,
  input  logic [31:0]       i_ex_pc,
  input  logic              i_ex_uncond,
  input  logic              i_ex_taken,
  input  logic [31:0]       i_ex_target,
  input  logic [IDX_W-1:0]  i_ex_pht_idx,
  input  logic              i_ex_mispred,
  output logic [PERF_W-1:0] o_br_cnt,
  output logic [PERF_W-1:0] o_mispred_cnt
);

  localparam bp_mode_e    P_MODE = bp_mode_e'(MODE);
  localparam int unsigned TAG_W  = 30 - IDX_W;

  btb_entry_t        r_btb [ENTRIES];
  logic [GHR_W-1:0]  r_ghr;
  logic [PERF_W-1:0] r_br_cnt;
  logic [PERF_W-1:0] r_mp_cnt;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  btb_entry_t        w_entry;
  logic              w_hit;
  logic [IDX_W-1:0]  w_pht_idx;
  logic              w_pht_taken;
  logic [IDX_W-1:0]  w_ex_idx;
  logic [TAG_W-1:0]  w_ex_tag;
  logic              w_unused;

  assign w_idx    = i_if_pc[IDX_W+1:2];
  assign w_tag    = i_if_pc[31:IDX_W+2];
  assign w_ex_idx = i_ex_pc[IDX_W+1:2];
  assign w_ex_tag = i_ex_pc[31:IDX_W+2];
  assign w_unused = ^{i_if_pc[1:0], i_ex_pc[1:0]};

  assign w_entry   = r_btb[w_idx];
  assign w_hit     = w_entry.valid && (w_entry.tag == BP_TAG_MAX_W'(w_tag));
  assign w_pht_idx = (P_MODE == BP_GSHARE) ? (w_idx ^ IDX_W'(r_ghr)) : w_idx;

  generate
    if (P_MODE != BP_STATIC) begin : g_pht
      bp_sat_counter_table #(
        .ENTRIES (ENTRIES),
        .CNT_W   (CNT_W)
      ) u_pht (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rd_idx    (w_pht_idx),
        .o_rd_taken  (w_pht_taken),
        .i_upd_vld   (i_ex_upd_vld && !i_ex_uncond),
        .i_upd_idx   (i_ex_pht_idx),
        .i_upd_taken (i_ex_taken)
      );
    end else begin : g_no_pht
      logic w_unused_pht;
      assign w_unused_pht = ^i_ex_pht_idx;
      assign w_pht_taken  = 1'b0;
    end
  endgenerate

  assign o_pred_hit    = w_hit;
  assign o_pred_taken  = w_hit && (w_entry.uncond || (P_MODE == BP_STATIC) || w_pht_taken);
  assign o_pred_target = w_hit ? w_entry.tgt : '0;
  assign o_pred_idx    = w_pht_idx;

  // Only taken resolutions allocate; tag/target need no reset since valid gates them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) r_btb[i].valid <= 1'b0;
    end else if (i_ex_upd_vld && i_ex_taken) begin
      r_btb[w_ex_idx] <= '{valid:  1'b1,
                           uncond: i_ex_uncond,
                           tag:    BP_TAG_MAX_W'(w_ex_tag),
                           tgt:    i_ex_target};
    end
  end

  // Shift form keeps GHR_W=1 legal: it then just holds the last outcome.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ghr <= '0;
    end else if ((P_MODE == BP_GSHARE) && i_ex_upd_vld && !i_ex_uncond) begin
      r_ghr <= (r_ghr << 1) | GHR_W'(i_ex_taken);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_br_cnt <= '0;
      r_mp_cnt <= '0;
    end else if (i_ex_upd_vld) begin
      if (r_br_cnt != '1) r_br_cnt <= r_br_cnt + PERF_W'(1);
      if (i_ex_mispred && (r_mp_cnt != '1)) r_mp_cnt <= r_mp_cnt + PERF_W'(1);
    end
  end

  assign o_br_cnt      = r_br_cnt;
  assign o_mispred_cnt = r_mp_cnt;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench: bimodal, gshare and static predictors driven by a shared stream of resolutions.
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        upd_vld;
  logic [31:0] ex_pc;
  logic        ex_uncond;
  logic        ex_taken;
  logic [31:0] ex_target;

  logic        bim_hit, gsh_hit, sta_hit;
  logic        bim_tkn, gsh_tkn, sta_tkn;
  logic [31:0] bim_tgt, gsh_tgt, sta_tgt;
  logic [5:0]  bim_idx, gsh_idx, sta_idx;
  logic [5:0]  bim_xidx, gsh_xidx, sta_xidx;
  logic        bim_xmp, gsh_xmp, sta_xmp;
  logic [31:0] bim_br, bim_mp, gsh_br, gsh_mp;
  logic [3:0]  sta_br, sta_mp;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  branch_predictor_btb #(.ENTRIES(64), .MODE(1)) u_bim (
    .i_clk(clk), .i_rst(rst), .i_if_pc(if_pc),
    .o_pred_hit(bim_hit), .o_pred_taken(bim_tkn), .o_pred_target(bim_tgt), .o_pred_idx(bim_idx),
    .i_ex_upd_vld(upd_vld), .i_ex_pc(ex_pc), .i_ex_uncond(ex_uncond), .i_ex_taken(ex_taken),
    .i_ex_target(ex_target), .i_ex_pht_idx(bim_xidx), .i_ex_mispred(bim_xmp),
    .o_br_cnt(bim_br), .o_mispred_cnt(bim_mp));

  branch_predictor_btb #(.ENTRIES(64), .MODE(2), .GHR_W(2)) u_gsh (
    .i_clk(clk), .i_rst(rst), .i_if_pc(if_pc),
    .o_pred_hit(gsh_hit), .o_pred_taken(gsh_tkn), .o_pred_target(gsh_tgt), .o_pred_idx(gsh_idx),
    .i_ex_upd_vld(upd_vld), .i_ex_pc(ex_pc), .i_ex_uncond(ex_uncond), .i_ex_taken(ex_taken),
    .i_ex_target(ex_target), .i_ex_pht_idx(gsh_xidx), .i_ex_mispred(gsh_xmp),
    .o_br_cnt(gsh_br), .o_mispred_cnt(gsh_mp));

  branch_predictor_btb #(.ENTRIES(64), .MODE(0), .PERF_W(4)) u_sta (
    .i_clk(clk), .i_rst(rst), .i_if_pc(if_pc),
    .o_pred_hit(sta_hit), .o_pred_taken(sta_tkn), .o_pred_target(sta_tgt), .o_pred_idx(sta_idx),
    .i_ex_upd_vld(upd_vld), .i_ex_pc(ex_pc), .i_ex_uncond(ex_uncond), .i_ex_taken(ex_taken),
    .i_ex_target(ex_target), .i_ex_pht_idx(sta_xidx), .i_ex_mispred(sta_xmp),
    .o_br_cnt(sta_br), .o_mispred_cnt(sta_mp));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic look(input logic [31:0] pc);
    @(negedge clk);
    if_pc = pc;
    #1;
  endtask

  // Fetch-time lookup of pc, then resolve it in the same cycle with the given outcome.
  task automatic branch(input logic [31:0] pc, input logic unc, input logic tk,
                        input logic [31:0] tg);
    look(pc);
    ex_pc     = pc;
    ex_uncond = unc;
    ex_taken  = tk;
    ex_target = tg;
    bim_xidx  = bim_idx;
    gsh_xidx  = gsh_idx;
    sta_xidx  = sta_idx;
    bim_xmp   = (bim_tkn !== tk) || (tk && (bim_tgt !== tg));
    gsh_xmp   = (gsh_tkn !== tk) || (tk && (gsh_tgt !== tg));
    sta_xmp   = (sta_tkn !== tk) || (tk && (sta_tgt !== tg));
    upd_vld   = 1'b1;
    @(negedge clk);
    upd_vld   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; upd_vld = 1'b0; if_pc = '0; ex_pc = '0; ex_uncond = 1'b0; ex_taken = 1'b0;
    ex_target = '0; bim_xidx = '0; gsh_xidx = '0; sta_xidx = '0;
    bim_xmp = 1'b0; gsh_xmp = 1'b0; sta_xmp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    look(32'h100);
    chk("rst_hit", bim_hit, 0);
    chk("rst_taken", bim_tkn, 0);
    chk("rst_target", bim_tgt, 0);
    chk("rst_idx", bim_idx, 0);
    chk("rst_gsh_idx", gsh_idx, 0);
    chk("rst_br_cnt", bim_br, 0);

    // Allocate, then train not-taken
    branch(32'h100, 1'b0, 1'b1, 32'h80);
    look(32'h100);
    chk("alloc_hit", bim_hit, 1);
    chk("alloc_taken", bim_tkn, 1);
    chk("alloc_target", bim_tgt, 32'h80);
    chk("gsh_idx_ghr1", gsh_idx, 1);
    chk("gsh_alloc_taken", gsh_tkn, 1);
    chk("sta_alloc_taken", sta_tkn, 1);
    branch(32'h100, 1'b0, 1'b0, 32'h104);
    branch(32'h100, 1'b0, 1'b0, 32'h104);
    look(32'h100);
    chk("nt_hit", bim_hit, 1);
    chk("nt_taken", bim_tkn, 0);
    chk("nt_target", bim_tgt, 32'h80);
    chk("sta_nt_taken", sta_tkn, 1);
    chk("gsh_idx_ghr0", gsh_idx, 0);
    chk("gsh_nt_taken", gsh_tkn, 1);
    chk("br_cnt3", bim_br, 3);
    chk("mp_cnt3", bim_mp, 3);

    // Aliasing at idx 0
    branch(32'h200, 1'b0, 1'b1, 32'h300);
    look(32'h100);
    chk("alias_old_hit", bim_hit, 0);
    chk("alias_old_tgt", bim_tgt, 0);
    look(32'h200);
    chk("alias_new_hit", bim_hit, 1);
    chk("alias_new_tgt", bim_tgt, 32'h300);
    chk("alias_new_taken", bim_tkn, 1);

    // JAL stays taken despite not-taken PHT training
    branch(32'h40, 1'b1, 1'b1, 32'h400);
    repeat (3) branch(32'h40, 1'b0, 1'b0, 32'h44);
    look(32'h40);
    chk("jal_hit", bim_hit, 1);
    chk("jal_taken", bim_tkn, 1);
    chk("jal_target", bim_tgt, 32'h400);

    // Not-taken never allocates; idle cycle with valid low changes nothing
    branch(32'h80, 1'b0, 1'b0, 32'h90);
    @(negedge clk);
    ex_pc = 32'h80; ex_taken = 1'b1; ex_target = 32'h90; bim_xmp = 1'b1;
    look(32'h80);
    chk("nt_noalloc_hit", bim_hit, 0);
    chk("idle_br_cnt", bim_br, 9);

    // Gshare vs bimodal on an alternating branch
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      branch(32'h100, 1'b0, 1'b1, 32'h80);
      branch(32'h100, 1'b0, 1'b0, 32'h104);
    end
    chk("gsh_mp", gsh_mp, 2);
    chk("gsh_br", gsh_br, 16);
    chk("bim_mp", bim_mp, 9);
    chk("bim_br", bim_br, 16);
    chk("gsh_lt_bim", 32'(gsh_mp < bim_mp), 1);
    chk("sta_br_sat", sta_br, 15);
    chk("sta_mp", sta_mp, 9);
    look(32'h100);
    chk("gsh_trained_idx", gsh_idx, 2);
    chk("gsh_trained_taken", gsh_tkn, 1);

    // Reset coincident with an update drops the update
    @(negedge clk);
    if_pc = 32'h140; ex_pc = 32'h140; ex_uncond = 1'b0; ex_taken = 1'b1; ex_target = 32'h500;
    bim_xmp = 1'b1; gsh_xmp = 1'b1; sta_xmp = 1'b1;
    upd_vld = 1'b1; rst = 1'b1;
    @(negedge clk);
    upd_vld = 1'b0; rst = 1'b0;
    look(32'h140);
    chk("rstupd_hit", bim_hit, 0);
    chk("rstupd_tgt", bim_tgt, 0);
    chk("rstupd_gsh_idx", gsh_idx, 16);
    chk("rstupd_br", bim_br, 0);
    chk("rstupd_mp", bim_mp, 0);
    chk("rstupd_sta_br", sta_br, 0);
    look(32'h100);
    chk("rst_clears_valid", bim_hit, 0);

    // Counter saturation (perf and PHT)
    repeat (20) branch(32'h10, 1'b0, 1'b1, 32'h20);
    chk("sat_sta_br", sta_br, 15);
    chk("sat_bim_br", bim_br, 20);
    chk("sat_bim_mp", bim_mp, 1);
    branch(32'h10, 1'b0, 1'b0, 32'h14);
    look(32'h10);
    chk("pht_sat_hi", bim_tkn, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
